// File: rtl/rgmii_tx_adapter.sv
// GMII-to-RGMII transmit adapter: gigabit DDR byte mode or 10/100 nibble mode, alignment pipeline, IFG enforcement.
// Define RGMII_TX_ERR_EN to encode GMII_TXER onto the falling-edge TX_CTL value.
module rgmii_tx_adapter #(
  parameter int PIPE_DELAY = 2,  // 1..4
  parameter int IFG_MIN    = 12  // 1..64
) (
  input  logic       GMII_GTXCLK,
  input  logic       rst_n,
  input  logic       speed_1000,
  input  logic [7:0] GMII_TXD,
  input  logic       GMII_TXEN,
  input  logic       GMII_TXER,
  output logic       TX_READY,
  output logic [3:0] RGMII_TXD_R,
  output logic [3:0] RGMII_TXD_F,
  output logic       RGMII_CTL_R,
  output logic       RGMII_CTL_F,
  output logic       BUSY,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(2 * IFG_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DATA        = 3'd1,
    S_NIB_HI      = 3'd2,
    S_NIB_LO_WAIT = 3'd3,
    S_IFG         = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [3:0]      hi_q, hi_d;
  logic            txer_q, txer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [9:0]      stage_d;
  logic [9:0]      pipe_q [PIPE_DELAY];
  logic            accept;
  logic            txer_eff;
  logic            idle_ctl_f;

`ifdef RGMII_TX_ERR_EN
  assign txer_eff   = GMII_TXER;
  assign idle_ctl_f = GMII_TXER & ~GMII_TXEN;
`else
  logic unused_txer;
  assign unused_txer = GMII_TXER;
  assign txer_eff    = 1'b0;
  assign idle_ctl_f  = 1'b0;
`endif

  // Handshake: a byte transfers on a rising edge where TX_READY and GMII_TXEN are both high;
  // while TX_READY is low the source keeps GMII_TXEN/TXD/TXER stable.
  assign accept = ready_q & GMII_TXEN;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    txer_d  = txer_q;
    cnt_d   = cnt_q;
    // stage_d = {ctl_r, ctl_f, txd_f, txd_r}
    stage_d = {1'b0, idle_ctl_f, 8'h00};
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d = speed_1000;
          if (speed_1000) begin
            stage_d = {1'b1, ~txer_eff, GMII_TXD[7:4], GMII_TXD[3:0]};
            state_d = S_DATA;
          end else begin
            stage_d = {1'b1, ~txer_eff, GMII_TXD[3:0], GMII_TXD[3:0]};
            hi_d    = GMII_TXD[7:4];
            txer_d  = txer_eff;
            state_d = S_NIB_HI;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          stage_d = {1'b1, ~txer_eff, GMII_TXD[7:4], GMII_TXD[3:0]};
        end else begin
          cnt_d   = CW'(IFG_MIN);
          state_d = S_IFG;
        end
      end
      S_NIB_HI: begin
        stage_d = {1'b1, ~txer_q, hi_q, hi_q};
        state_d = S_NIB_LO_WAIT;
      end
      S_NIB_LO_WAIT: begin
        if (accept) begin
          stage_d = {1'b1, ~txer_eff, GMII_TXD[3:0], GMII_TXD[3:0]};
          hi_d    = GMII_TXD[7:4];
          txer_d  = txer_eff;
          state_d = S_NIB_HI;
        end else begin
          cnt_d   = CW'(2 * IFG_MIN);
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        // Counter saturates at zero; the last gap cycle is the one holding a count of 1.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_NIB_LO_WAIT);
  end

  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      hi_q    <= 4'h0;
      txer_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hi_q    <= hi_d;
      txer_q  <= txer_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Data and control share one shift register so they can never skew against each other.
  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign TX_READY    = ready_q;
  assign RGMII_TXD_R = pipe_q[PIPE_DELAY-1][3:0];
  assign RGMII_TXD_F = pipe_q[PIPE_DELAY-1][7:4];
  assign RGMII_CTL_F = pipe_q[PIPE_DELAY-1][8];
  assign RGMII_CTL_R = pipe_q[PIPE_DELAY-1][9];
  assign BUSY        = (state_q != S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_rgmii_tx_adapter.sv
// Bench for rgmii_tx_adapter: per-cycle vector table plus hand sequences for back-to-back frames and reset.
module tb_rgmii_tx_adapter;

  logic       clk;
  logic       rst_n;
  logic       speed_1000;
  logic [7:0] txd;
  logic       txen;
  logic       txer;
  logic       tx_ready;
  logic [3:0] txd_r;
  logic [3:0] txd_f;
  logic       ctl_r;
  logic       ctl_f;
  logic       busy;
  logic [2:0] state_dbg;

`ifdef RGMII_TX_ERR_EN
  localparam logic ERR_CF   = 1'b0;
  localparam logic ERR_IDLE = 1'b1;
`else
  localparam logic ERR_CF   = 1'b1;
  localparam logic ERR_IDLE = 1'b0;
`endif

  rgmii_tx_adapter #(.PIPE_DELAY(2), .IFG_MIN(12)) dut (
    .GMII_GTXCLK (clk),
    .rst_n       (rst_n),
    .speed_1000  (speed_1000),
    .GMII_TXD    (txd),
    .GMII_TXEN   (txen),
    .GMII_TXER   (txer),
    .TX_READY    (tx_ready),
    .RGMII_TXD_R (txd_r),
    .RGMII_TXD_F (txd_f),
    .RGMII_CTL_R (ctl_r),
    .RGMII_CTL_F (ctl_f),
    .BUSY        (busy),
    .state_o     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       er;
    logic       spd;
    logic       rdy;
    logic [3:0] tr;
    logic [3:0] tf;
    logic       cr;
    logic       cf;
    logic       busy;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] exp_q[$];
  int         out_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc_n = 0;
  int         low_cnt = 0;
  logic       sb_on = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  function automatic void add(input logic en, input logic [7:0] d, input logic er, input logic spd,
                              input logic rdy, input logic [3:0] tr, input logic [3:0] tf,
                              input logic cr, input logic cf, input logic bsy);
    vec_t v;
    v.en = en; v.d = d; v.er = er; v.spd = spd;
    v.rdy = rdy; v.tr = tr; v.tf = tf; v.cr = cr; v.cf = cf; v.busy = bsy;
    vq.push_back(v);
  endfunction

  function automatic void add_idle(input int n, input logic rdy, input logic bsy);
    for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, 1'b1, rdy, 4'h0, 4'h0, 1'b0, 1'b0, bsy);
  endfunction

  // driver: one clock cycle, inputs changed just after the rising edge, outputs sampled on the falling edge
  task automatic cyc(input logic en, input logic [7:0] d, input logic er, input logic spd);
    @(posedge clk);
    #1;
    txen = en; txd = d; txer = er; speed_1000 = spd;
    @(negedge clk);
    cyc_n++;
    if (!tx_ready) low_cnt++;
    if (sb_on && ctl_r) begin
      out_q.push_back(cyc_n);
      if (exp_q.size() == 0) chk("sb unexpected byte", {24'h0, txd_f, txd_r}, 32'hffff_ffff);
      else chk("sb byte", {24'h0, txd_f, txd_r}, {24'h0, exp_q.pop_front()});
    end
  endtask

  initial begin
    logic acc;
    logic done;
    int   gap;

    rst_n = 1'b0; txen = 1'b0; txd = 8'h00; txer = 1'b0; speed_1000 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", tx_ready, 1);
    chk("reset txd", {24'h0, txd_f, txd_r}, 0);
    chk("reset ctl", {30'h0, ctl_r, ctl_f}, 0);
    chk("reset busy", busy, 0);
    chk("reset state", state_dbg, 0);
    rst_n = 1'b1;

    // gigabit 4-byte frame
    add(1, 8'h55, 0, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    add(1, 8'hD5, 0, 1, 1, 4'h0, 4'h0, 0, 0, 1);
    add(1, 8'hA1, 0, 1, 1, 4'h5, 4'h5, 1, 1, 1);
    add(1, 8'h3C, 0, 1, 1, 4'h5, 4'hD, 1, 1, 1);
    add(0, 8'h00, 0, 1, 1, 4'h1, 4'hA, 1, 1, 1);
    add(0, 8'h00, 0, 1, 0, 4'hC, 4'h3, 1, 1, 1);
    add_idle(11, 0, 1);
    add_idle(1, 1, 0);
    // nibble frame 0xA1, 0x3C; TXEN drops while the last high nibble is emitted
    add(1, 8'hA1, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    add(1, 8'h3C, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    add(1, 8'h3C, 0, 0, 1, 4'h1, 4'h1, 1, 1, 1);
    add(0, 8'h00, 0, 0, 0, 4'hA, 4'hA, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 4'hC, 4'hC, 1, 1, 1);
    add(0, 8'h00, 0, 0, 0, 4'h3, 4'h3, 1, 1, 1);
    add_idle(23, 0, 1);
    add_idle(1, 1, 0);
    // gigabit frame with TXER on byte 3, then TXER alone while idle
    add(1, 8'h01, 0, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    add(1, 8'h02, 0, 1, 1, 4'h0, 4'h0, 0, 0, 1);
    add(1, 8'h03, 1, 1, 1, 4'h1, 4'h0, 1, 1, 1);
    add(1, 8'h04, 0, 1, 1, 4'h2, 4'h0, 1, 1, 1);
    add(0, 8'h00, 0, 1, 1, 4'h3, 4'h0, 1, ERR_CF, 1);
    add(0, 8'h00, 0, 1, 0, 4'h4, 4'h0, 1, 1, 1);
    add_idle(11, 0, 1);
    add_idle(1, 1, 0);
    add(0, 8'h00, 1, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    add_idle(1, 1, 0);
    add(0, 8'h00, 0, 1, 1, 4'h0, 4'h0, 0, ERR_IDLE, 0);
    add_idle(1, 1, 0);
    // speed_1000 rises mid nibble frame: frame stays nibble, next frame is gigabit
    add(1, 8'h5A, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    add(1, 8'hC3, 0, 1, 0, 4'h0, 4'h0, 0, 0, 1);
    add(1, 8'hC3, 0, 1, 1, 4'hA, 4'hA, 1, 1, 1);
    add(0, 8'h00, 0, 1, 0, 4'h5, 4'h5, 1, 1, 1);
    add(0, 8'h00, 0, 1, 1, 4'h3, 4'h3, 1, 1, 1);
    add(0, 8'h00, 0, 1, 0, 4'hC, 4'hC, 1, 1, 1);
    add_idle(23, 0, 1);
    add_idle(1, 1, 0);
    add(1, 8'h7E, 0, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 1, 4'h0, 4'h0, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 4'hE, 4'h7, 1, 1, 1);
    add_idle(11, 0, 1);
    add_idle(1, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].en, vq[i].d, vq[i].er, vq[i].spd);
      chk($sformatf("row%0d ready", i), tx_ready, vq[i].rdy);
      chk($sformatf("row%0d txd_r", i), txd_r, vq[i].tr);
      chk($sformatf("row%0d txd_f", i), txd_f, vq[i].tf);
      chk($sformatf("row%0d ctl_r", i), ctl_r, vq[i].cr);
      chk($sformatf("row%0d ctl_f", i), ctl_f, vq[i].cf);
      chk($sformatf("row%0d busy", i), busy, vq[i].busy);
    end

    // back-to-back gigabit frames, source reasserts TXEN two cycles after the drop
    out_q.delete();
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    sb_on = 1'b1;
    low_cnt = 0;
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      cyc(1, 8'h33, 0, 1);
      if (tx_ready) acc = 1'b1;
    end
    chk("b2b second frame accepted", acc, 1);
    chk("b2b ready low cycles", low_cnt, 12);
    cyc(1, 8'h44, 0, 1);
    cyc(0, 8'h00, 0, 1);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      cyc(0, 8'h00, 0, 1);
      if (tx_ready && !busy) done = 1'b1;
    end
    chk("b2b returned to idle", done, 1);
    chk("b2b scoreboard drained", exp_q.size(), 0);
    chk("b2b output byte count", out_q.size(), 4);
    gap = 0;
    for (int i = 1; i < out_q.size(); i++) begin
      if (out_q[i] - out_q[i-1] > 1) gap = out_q[i] - out_q[i-1];
    end
    chk("b2b gap at least 12", (gap >= 12), 1);
    sb_on = 1'b0;

    // reset pulse during byte 5 of a 10-byte gigabit frame
    for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 1);
    @(posedge clk);
    #1;
    txen = 1'b1; txd = 8'h14;
    #2;
    chk("pre-reset txd_r", txd_r, 4'h2);
    chk("pre-reset txd_f", txd_f, 4'h1);
    chk("pre-reset ctl_r", ctl_r, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset txd", {24'h0, txd_f, txd_r}, 0);
    chk("async reset ctl", {30'h0, ctl_r, ctl_f}, 0);
    chk("async reset busy", busy, 0);
    chk("async reset ready", tx_ready, 1);
    @(negedge clk);
    txen = 1'b0; txd = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 8'h00, 0, 1);
      chk($sformatf("post-reset%0d txd", k), {24'h0, txd_f, txd_r}, 0);
      chk($sformatf("post-reset%0d ctl", k), {30'h0, ctl_r, ctl_f}, 0);
      chk($sformatf("post-reset%0d ready", k), tx_ready, 1);
      chk($sformatf("post-reset%0d busy", k), busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_adapter.md
# rgmii_tx_adapter

- Parametrised GMII-to-RGMII transmit adapter between the GMII frame generator (GMII_send) and the RGMII output DDR cells.
- Gigabit mode: each byte maps to one DDR nibble pair per cycle. 10/100 mode: each byte is serialised into two SDR nibble cycles, with a ready handshake back-pressuring the source.
- Also provides a programmable alignment pipeline, minimum inter-frame-gap enforcement, and optional TX_ER encoding on the RGMII control line.
- Outputs are per-edge rise/fall values that drive one ODDR per pin.

## Interface
Parameters:
- PIPE_DELAY, default 2: register stages from byte accept to the rise/fall outputs; legal range 1..4.
- IFG_MIN, default 12: minimum idle byte-times enforced between frames; legal range 1..64.

Ports:
- GMII_GTXCLK  in  1  TX clock: 125 MHz at 1000, 25 MHz at 100, 2.5 MHz at 10; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- speed_1000  in  1  1 = gigabit DDR byte mode, 0 = 10/100 nibble mode; latched at frame start.
- GMII_TXD  in  8  data byte.
- GMII_TXEN  in  1  frame enable; a contiguous high run is one frame.
- GMII_TXER  in  1  transmit error for the current byte.
- TX_READY  out  1  byte is accepted when TX_READY and GMII_TXEN are both high.
- RGMII_TXD_R  out  4  TXD value for the rising edge.
- RGMII_TXD_F  out  4  TXD value for the falling edge.
- RGMII_CTL_R  out  1  TX_CTL value for the rising edge.
- RGMII_CTL_F  out  1  TX_CTL value for the falling edge.
- BUSY  out  1  high from first accept until the inter-frame gap completes.

## Operation
Reset values:
- All outputs 0 except TX_READY = 1.
- State IDLE, pipeline cleared.

State machine:
- IDLE:
  - TX_READY = 1.
  - On accept: latch speed_1000 into mode_g.
  - Go to DATA if mode_g = 1, or NIB_HI if mode_g = 0.
- DATA (gigabit):
  - TX_READY = 1; one byte accepted per cycle.
  - GMII_TXEN low moves to IFG.
- NIB_HI (10/100):
  - TX_READY = 0; the high nibble of the held byte is emitted.
  - Next cycle goes to NIB_LO_WAIT.
- NIB_LO_WAIT:
  - TX_READY = 1.
  - GMII_TXEN high: accept, emit the low nibble, go to NIB_HI.
  - GMII_TXEN low: go to IFG.
- IFG:
  - TX_READY = 0; counter loads IFG_MIN (gigabit) or 2*IFG_MIN (nibble) cycles.
  - Go to IDLE when the counter reaches 0.
  - Source must hold GMII_TXEN/TXD stable while TX_READY = 0.

Output mapping:
- Gigabit:
  - TXD_R = byte[3:0], TXD_F = byte[7:4].
  - CTL_R = TXEN, CTL_F = TXEN ^ TXER.
- Nibble:
  - TXD_R = TXD_F = the current nibble, low nibble first.
  - CTL_R = TXEN, CTL_F = TXEN ^ TXER (TXER held for both nibbles).
- Idle: TXD 0, CTL 0 on both edges.

Rules and boundary cases:
- speed_1000 is ignored mid-frame; a change takes effect at the next IDLE accept.
- IFG counter width is $clog2(2*IFG_MIN+1). It does not wrap: it saturates at 0.
- rst_n low mid-frame: outputs 0 immediately (asynchronous), frame truncated, pipeline flushed. After release, no residual bytes appear.
- TXEN drop in the same cycle as the last nibble: the nibble still completes, then IFG.
- BUSY falls in the same cycle the state returns to IDLE.

## Timing
- Gigabit latency: byte accepted at cycle N appears on RGMII_*_R/F at N+PIPE_DELAY.
- Nibble latency:
  - Low nibble at N+PIPE_DELAY, high nibble at N+PIPE_DELAY+1.
  - Throughput is one byte per 2 cycles.
- Data and CTL traverse identical pipeline depth, so skew between them is 0 cycles.
- TX_READY is registered: it changes only on a GMII_GTXCLK rising edge.
- Back-to-back frames: first accept of the next frame no earlier than IFG_MIN byte-times after the last output byte.

## Configuration
- RGMII_TX_ERR_EN defined:
  - GMII_TXER is encoded into CTL_F as TXEN ^ TXER.
  - TXER asserted while TXEN is low produces CTL_F = 1 (carrier extend/error), passed through unchanged.
- Not defined:
  - GMII_TXER is ignored; CTL_F = CTL_R = TXEN.
  - Port remains present, unused.

## Test plan
- Gigabit, PIPE_DELAY=2, 4-byte frame 0x55,0xD5,0xA1,0x3C:
  - TXD_R/F = 5/5, 5/D, 1/A, C/3 at cycles 2..5.
  - CTL_R = CTL_F = 1 throughout; TX_READY constantly 1.
- Nibble mode, byte 0xA1 then 0x3C:
  - TXD sequence 1,A,C,3 on 4 consecutive cycles, TXD_R = TXD_F.
  - TX_READY toggles 1,0,1,0.
- Back-to-back frames, gigabit, IFG_MIN=12, source reasserts TXEN 2 cycles after the drop:
  - TX_READY low for exactly 12 cycles.
  - Second frame's first output byte is ≥12 cycles after the last output byte.
- RGMII_TX_ERR_EN defined, TXER=1 on byte 3 of a gigabit frame: only that cycle shows CTL_R=1, CTL_F=0. Repeat without the macro: CTL_F=1 for that cycle.
- speed_1000 toggled 0→1 mid nibble frame: frame finishes in nibble mode; next frame runs in gigabit.
- rst_n pulsed low during byte 5 of a 10-byte frame:
  - All outputs 0 in the same cycle.
  - After release, TX_READY=1 and BUSY=0, with no stale data.
